depth_test_unit: RTL and testbench

DEPTH_TEST_UNIT -- requirements
Module: depth_test_unit

---
 rtl/rast_pkg.sv | 21 ++
 rtl/depth_compare.sv | 21 ++
 rtl/depth_test_unit.sv | 148 ++++++++++++++
 tb/tb_depth_test_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rast_pkg.sv
// rast_pkg: shared depth-compare function and depth-test FSM state encodings
package rast_pkg;
  typedef enum logic [2:0] {
    Z_NEVER    = 3'd0,
    Z_LESS     = 3'd1,
    Z_LEQUAL   = 3'd2,
    Z_GREATER  = 3'd3,
    Z_GEQUAL   = 3'd4,
    Z_EQUAL    = 3'd5,
    Z_NOTEQUAL = 3'd6,
    Z_ALWAYS   = 3'd7
  } z_func_t;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESULT  = 3'd4,
    CLEAR   = 3'd5
  } state_t;
endpackage

// File: rtl/depth_compare.sv
// depth_compare: unsigned incoming-vs-stored depth comparison for one compare function
module depth_compare
  import rast_pkg::*;
#(
  parameter int Z_SIZE = 16
) (
  input  z_func_t           func,
  input  logic [Z_SIZE-1:0] a,
  input  logic [Z_SIZE-1:0] b,
  output logic              pass
);
  // a is the incoming fragment depth, b the stored depth
  always_comb
    pass = func == Z_LESS     ? a <  b :
           func == Z_LEQUAL   ? a <= b :
           func == Z_GREATER  ? a >  b :
           func == Z_GEQUAL   ? a >= b :
           func == Z_EQUAL    ? a == b :
           func == Z_NOTEQUAL ? a != b :
           func == Z_ALWAYS;
endmodule

// File: rtl/depth_test_unit.sv
// depth_test_unit: per-pixel depth test against a memory-resident depth buffer, plus buffer clear
module depth_test_unit
  import rast_pkg::*;
#(
  parameter int Z_SIZE    = 16,
  parameter int X_RES     = 640,
  parameter int Y_RES     = 480,
  parameter int ADDR_SIZE = 32,
  parameter int Z_BYTES   = (Z_SIZE + 7) / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_SIZE-1:0]      buffer_base_address_i,
  input  logic [2:0]                z_depth_func_i,
  input  logic                      depth_write_en_i,
  input  logic [Z_SIZE-1:0]         clear_value_i,
  input  logic                      clear_start_i,
  output logic                      clear_busy_o,
  output logic                      clear_done_o,
  input  logic                      px_valid_i,
  output logic                      px_ready_o,
  input  logic [$clog2(X_RES)-1:0]  px_x_i,
  input  logic [$clog2(Y_RES)-1:0]  px_y_i,
  input  logic [Z_SIZE-1:0]         px_z_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      res_pass_o,
  output logic [$clog2(X_RES)-1:0]  res_x_o,
  output logic [$clog2(Y_RES)-1:0]  res_y_o,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic                      mem_we_o,
  output logic [ADDR_SIZE-1:0]      mem_addr_o,
  output logic [Z_SIZE-1:0]         mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [Z_SIZE-1:0]         mem_rdata_i,
  output logic                      mem_rready_o
);
  localparam int XW = $clog2(X_RES);
  localparam int YW = $clog2(Y_RES);
  localparam int N  = X_RES * Y_RES;
  localparam int CW = $clog2(N + 1);
  localparam logic [XW:0] X_LIM = (XW + 1)'(X_RES);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(Y_RES);
  state_t                state, state_n;
  z_func_t               func_q;
  logic                  pend_q, we_q, oob_q, pass_q, done_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [Z_SIZE-1:0]     z_q, clr_val_q;
  logic [ADDR_SIZE-1:0]  addr_q, clr_addr_q, px_addr;
  logic [CW-1:0]         clr_cnt_q;
  logic                  idle_free, accept, clr_start, clr_fire, clr_last, cmp_pass, px_oob;
  depth_compare #(.Z_SIZE(Z_SIZE)) u_cmp (
    .func (func_q),
    .a    (z_q),
    .b    (mem_rdata_i),
    .pass (cmp_pass)
  );
  // A pixel is latched first and decided on the following IDLE cycle (pend_q),
  // which keeps the address multiply off the decision path and sets the 2-cycle minimum latency
  always_comb begin
    idle_free = state == IDLE && !pend_q;
    accept    = idle_free && !clear_start_i && px_valid_i;
    clr_start = idle_free && clear_start_i;
    clr_fire  = state == CLEAR && mem_req_ready_i;
    clr_last  = clr_cnt_q == CW'(N - 1);
    px_oob    = {1'b0, px_x_i} >= X_LIM || {1'b0, px_y_i} >= Y_LIM;
    px_addr   = buffer_base_address_i +
                (ADDR_SIZE'(px_y_i) * ADDR_SIZE'(X_RES) + ADDR_SIZE'(px_x_i)) * ADDR_SIZE'(Z_BYTES);
  end
  // Next-state selection
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pend_q ? ((oob_q || func_q == Z_NEVER) ? RESULT :
                                   func_q == Z_ALWAYS ? (we_q ? WR_REQ : RESULT) : RD_REQ) :
                         clear_start_i ? CLEAR : IDLE;
      RD_REQ:  state_n = mem_req_ready_i ? RD_WAIT : RD_REQ;
      RD_WAIT: state_n = mem_rvalid_i ? ((cmp_pass && we_q) ? WR_REQ : RESULT) : RD_WAIT;
      WR_REQ:  state_n = mem_req_ready_i ? RESULT : WR_REQ;
      RESULT:  state_n = res_ready_i ? IDLE : RESULT;
      CLEAR:   state_n = (clr_fire && clr_last) ? IDLE : CLEAR;
      default: state_n = IDLE;
    endcase
  end
  // Outputs decoded from state; address/data forced to zero outside their states
  always_comb begin
    px_ready_o      = idle_free && !clear_start_i && !rst_i;
    clear_busy_o    = state == CLEAR;
    clear_done_o    = done_q;
    mem_req_valid_o = state == RD_REQ || state == WR_REQ || state == CLEAR;
    mem_we_o        = state == WR_REQ || state == CLEAR;
    mem_rready_o    = state == RD_WAIT;
    mem_addr_o      = state == CLEAR ? clr_addr_q : (state == RD_REQ || state == WR_REQ) ? addr_q : '0;
    mem_wdata_o     = state == CLEAR ? clr_val_q : state == WR_REQ ? z_q : '0;
    res_valid_o     = state == RESULT;
    res_pass_o      = state == RESULT && pass_q;
    res_x_o         = state == RESULT ? x_q : '0;
    res_y_o         = state == RESULT ? y_q : '0;
  end
  // State, pixel context and clear progress registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pend_q     <= 1'b0;
      func_q     <= Z_NEVER;
      we_q       <= 1'b0;
      oob_q      <= 1'b0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      addr_q     <= '0;
      clr_val_q  <= '0;
      clr_addr_q <= '0;
      clr_cnt_q  <= '0;
    end else begin
      state  <= state_n;
      done_q <= clr_fire && clr_last;
      if (accept) begin
        pend_q <= 1'b1;
        x_q    <= px_x_i;
        y_q    <= px_y_i;
        z_q    <= px_z_i;
        func_q <= z_func_t'(z_depth_func_i);
        we_q   <= depth_write_en_i;
        oob_q  <= px_oob;
        addr_q <= px_addr;
      end
      if (state == IDLE && pend_q) begin
        pend_q <= 1'b0;
        pass_q <= !oob_q && func_q == Z_ALWAYS;
      end
      if (state == RD_WAIT && mem_rvalid_i) pass_q <= cmp_pass;
      if (clr_start) begin
        clr_val_q  <= clear_value_i;
        clr_addr_q <= buffer_base_address_i;
        clr_cnt_q  <= '0;
      end
      if (clr_fire) begin
        clr_addr_q <= clr_addr_q + ADDR_SIZE'(Z_BYTES);
        clr_cnt_q  <= clr_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_depth_test_unit.sv
// tb_depth_test_unit: directed checks of depth test, clear and reset behaviour
module tb_depth_test_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base = '0;
  logic [2:0]  func = '0;
  logic        dwe = 1'b0;
  logic [7:0]  clr_val = '0;
  logic        clr_start = 1'b0;
  logic        px_valid_a = 1'b0, px_valid_b = 1'b0;
  logic [2:0]  px_x = '0;
  logic [1:0]  px_y = '0;
  logic [7:0]  px_z = '0;
  logic        res_ready = 1'b0;
  logic        mem_ready = 1'b1;
  logic [7:0]  stored = '0;
  logic        mem_rvalid;
  logic        a_busy, a_done, a_px_ready, a_res_valid, a_res_pass, a_req, a_we, a_rready;
  logic [1:0]  a_res_x, a_res_y;
  logic [15:0] a_addr;
  logic [7:0]  a_wdata;
  logic        b_busy, b_done, b_px_ready, b_res_valid, b_res_pass, b_req, b_we, b_rready;
  logic [2:0]  b_res_x;
  logic [1:0]  b_res_y;
  logic [15:0] b_addr;
  logic [7:0]  b_wdata;
  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, b_req_cnt = 0;
  logic [15:0] wr_addr [0:31];
  logic [7:0]  wr_data [0:31];
  logic [15:0] last_ra;
  logic        r_pass;
  int          r_lat;
  always #5 clk = ~clk;
  assign mem_rvalid = a_rready;
  depth_test_unit #(.Z_SIZE(8), .X_RES(4), .Y_RES(4), .ADDR_SIZE(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .buffer_base_address_i(base), .z_depth_func_i(func),
    .depth_write_en_i(dwe), .clear_value_i(clr_val), .clear_start_i(clr_start),
    .clear_busy_o(a_busy), .clear_done_o(a_done), .px_valid_i(px_valid_a), .px_ready_o(a_px_ready),
    .px_x_i(px_x[1:0]), .px_y_i(px_y), .px_z_i(px_z), .res_valid_o(a_res_valid), .res_ready_i(res_ready),
    .res_pass_o(a_res_pass), .res_x_o(a_res_x), .res_y_o(a_res_y), .mem_req_valid_o(a_req),
    .mem_req_ready_i(mem_ready), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(stored), .mem_rready_o(a_rready));
  depth_test_unit #(.Z_SIZE(8), .X_RES(5), .Y_RES(4), .ADDR_SIZE(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .buffer_base_address_i(base), .z_depth_func_i(func),
    .depth_write_en_i(dwe), .clear_value_i(clr_val), .clear_start_i(1'b0),
    .clear_busy_o(b_busy), .clear_done_o(b_done), .px_valid_i(px_valid_b), .px_ready_o(b_px_ready),
    .px_x_i(px_x), .px_y_i(px_y), .px_z_i(px_z), .res_valid_o(b_res_valid), .res_ready_i(res_ready),
    .res_pass_o(b_res_pass), .res_x_o(b_res_x), .res_y_o(b_res_y), .mem_req_valid_o(b_req),
    .mem_req_ready_i(mem_ready), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(stored), .mem_rready_o(b_rready));
  // memory-side monitor: logs every accepted request and every done pulse
  always @(posedge clk) begin
    if (a_req && mem_ready && a_we) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt] <= a_addr;
        wr_data[wr_cnt] <= a_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (a_req && mem_ready && !a_we) begin
      rd_cnt  <= rd_cnt + 1;
      last_ra <= a_addr;
    end
    if (a_done) done_cnt <= done_cnt + 1;
    if (b_req) b_req_cnt <= b_req_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic run_px(input bit on_b, input logic [2:0] x, input logic [1:0] y, input logic [7:0] z,
                        input logic [2:0] f, input logic we);
    int n;
    @(negedge clk);
    wr_cnt = 0; rd_cnt = 0; b_req_cnt = 0;
    px_x = x; px_y = y; px_z = z; func = f; dwe = we;
    n = 0;
    while (!(on_b ? b_px_ready : a_px_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (on_b) px_valid_b = 1'b1;
    else px_valid_a = 1'b1;
    @(negedge clk);
    px_valid_a = 1'b0; px_valid_b = 1'b0;
    r_lat = 1;
    while (!(on_b ? b_res_valid : a_res_valid) && r_lat < 50) begin
      @(negedge clk);
      r_lat++;
    end
    r_pass = on_b ? b_res_pass : a_res_pass;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask
  initial begin
    int bad;
    repeat (2) @(negedge clk);
    check("rst_px_ready", a_px_ready, 0);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_mem_req", a_req, 0);
    check("rst_busy", a_busy, 0);
    check("rst_addr", a_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_px_ready", a_px_ready, 1);
    base = 16'h0200; clr_val = 8'hFF; clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    wr_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 100 && a_busy; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("clr_writes", wr_cnt, 16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (wr_addr[i] !== 16'h0200 + 16'(i) || wr_data[i] !== 8'hFF) bad++;
    check("clr_addr_data", bad, 0);
    check("clr_done_once", done_cnt, 1);
    check("clr_busy_end", a_busy, 0);
    base = 16'h0100;
    stored = 8'h80;
    run_px(0, 3'd2, 2'd1, 8'h40, 3'd1, 1'b1);
    check("less_pass", r_pass, 1);
    check("less_reads", rd_cnt, 1);
    check("less_raddr", last_ra, 16'h0106);
    check("less_writes", wr_cnt, 1);
    check("less_waddr", wr_addr[0], 16'h0106);
    check("less_wdata", wr_data[0], 8'h40);
    stored = 8'h40;
    run_px(0, 3'd3, 2'd3, 8'h80, 3'd1, 1'b1);
    check("lessf_pass", r_pass, 0);
    check("lessf_reads", rd_cnt, 1);
    check("lessf_writes", wr_cnt, 0);
    run_px(0, 3'd0, 2'd2, 8'h40, 3'd4, 1'b0);
    check("geq_pass", r_pass, 1);
    check("geq_writes", wr_cnt, 0);
    run_px(0, 3'd1, 2'd0, 8'h11, 3'd7, 1'b0);
    check("always_pass", r_pass, 1);
    check("always_lat", r_lat, 2);
    check("always_mem", rd_cnt + wr_cnt, 0);
    run_px(0, 3'd1, 2'd2, 8'h22, 3'd7, 1'b1);
    check("always_we_reads", rd_cnt, 0);
    check("always_we_writes", wr_cnt, 1);
    check("always_we_addr", wr_addr[0], 16'h0109);
    stored = 8'h33;
    run_px(0, 3'd0, 2'd0, 8'h34, 3'd5, 1'b1);
    check("eq_pass", r_pass, 0);
    run_px(0, 3'd0, 2'd0, 8'h34, 3'd6, 1'b1);
    check("neq_pass", r_pass, 1);
    check("neq_writes", wr_cnt, 1);
    run_px(0, 3'd2, 2'd2, 8'h00, 3'd0, 1'b1);
    check("never_pass", r_pass, 0);
    check("never_mem", rd_cnt + wr_cnt, 0);
    run_px(1, 3'd5, 2'd1, 8'h00, 3'd7, 1'b1);
    check("oob_pass", r_pass, 0);
    check("oob_mem", b_req_cnt, 0);
    run_px(1, 3'd4, 2'd1, 8'h00, 3'd7, 1'b0);
    check("b_edge_pass", r_pass, 1);
    @(negedge clk);
    wr_cnt = 0; rd_cnt = 0;
    clr_start = 1'b1; px_valid_a = 1'b1; px_z = 8'h10; func = 3'd7;
    #1;
    check("race_px_ready", a_px_ready, 0);
    @(negedge clk);
    clr_start = 1'b0; px_valid_a = 1'b0;
    check("race_busy", a_busy, 1);
    for (int n = 0; n < 50 && wr_cnt < 2; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_req", a_req, 0);
    check("mid_rst_px_ready", a_px_ready, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_writes", wr_cnt, 3);
    check("post_rst_reads", rd_cnt, 0);
    check("post_rst_res", a_res_valid, 0);
    check("post_rst_done", a_done, 0);
    check("post_rst_idle", a_px_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
